// File: rtl/list_prefetch_cache.sv
// Multi-line prefetch cache: packets with a toggle tag fill a ring of line slots, and the stored
// payload words stream out one per beat through a registered valid/ready output.
module list_prefetch_cache #(
  parameter int unsigned DW = 32,
  parameter int unsigned FS = 8,
  parameter int unsigned BS = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [FS*DW-1:0]        IN,
  input  logic                    i_valid,
  output logic                    next_ready,
  input  logic                    i_flush,
  output logic [DW-1:0]           OUT,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_last,
  output logic [$clog2(BS+1)-1:0] o_level
);

  localparam int unsigned TS = FS - 1;
  localparam int unsigned AW = $clog2(BS);
  localparam int unsigned IW = (TS > 1) ? $clog2(TS) : 1;
  localparam int unsigned LW = $clog2(BS + 1);

  typedef logic [TS-1:0][DW-1:0] line_t;

  line_t         line_q [BS];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [LW-1:0] level_q, level_d;
  logic [DW-1:0] last_tag_q, last_tag_d;
  logic [DW-1:0] out_q, out_d;
  logic          o_valid_q, o_valid_d;
  logic          o_last_q, o_last_d;

  logic accept;
  logic store;
  logic load;
  logic line_done;

  always_comb begin
    next_ready = !i_flush && (level_q < LW'(BS));
    accept     = i_valid && next_ready;
    // Duplicate tags are acknowledged but never stored.
    store      = accept && (IN[DW-1:0] != last_tag_q);
    load       = (!o_valid_q || i_ready) && (level_q != '0) && !i_flush;
    line_done  = load && (idx_q == IW'(TS - 1));
  end

  always_comb begin
    wr_d       = wr_q;
    rd_d       = rd_q;
    idx_d      = idx_q;
    level_d    = level_q;
    last_tag_d = last_tag_q;
    out_d      = out_q;
    o_valid_d  = o_valid_q;
    o_last_d   = o_last_q;
    if (i_flush) begin
      wr_d      = '0;
      rd_d      = '0;
      idx_d     = '0;
      level_d   = '0;
      o_valid_d = 1'b0;
      o_last_d  = 1'b0;
    end else begin
      if (store) begin
        wr_d       = wr_q + 1'b1;
        last_tag_d = IN[DW-1:0];
      end
      if (load) begin
        out_d     = line_q[rd_q][idx_q];
        o_valid_d = 1'b1;
        o_last_d  = line_done;
        if (line_done) begin
          idx_d = '0;
          rd_d  = rd_q + 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else if (!o_valid_q || i_ready) begin
        o_valid_d = 1'b0;
      end
      // A line stored and a line freed in the same cycle cancel out.
      level_d = level_q + LW'(store) - LW'(line_done);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_q       <= '0;
      rd_q       <= '0;
      idx_q      <= '0;
      level_q    <= '0;
      last_tag_q <= DW'(1);
      out_q      <= '0;
      o_valid_q  <= 1'b0;
      o_last_q   <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      idx_q      <= idx_d;
      level_q    <= level_d;
      last_tag_q <= last_tag_d;
      out_q      <= out_d;
      o_valid_q  <= o_valid_d;
      o_last_q   <= o_last_d;
    end
  end

  // Line storage needs no reset: occupancy is tracked by level_q.
  always_ff @(posedge CLK) begin
    if (store) begin
      for (int k = 0; k < TS; k++) begin
        line_q[wr_q][k] <= IN[(k+1)*DW +: DW];
      end
    end
  end

  assign OUT     = out_q;
  assign o_valid = o_valid_q;
  assign o_last  = o_last_q;
  assign o_level = level_q;

endmodule

// File: tb/tb_list_prefetch_cache.sv
// Scoreboard bench for list_prefetch_cache: accepted packets push expected words, the output
// monitor pops and compares them on the falling edge.
module tb_list_prefetch_cache;

  localparam int unsigned DW = 32;
  localparam int unsigned FS = 8;
  localparam int unsigned BS = 2;
  localparam int unsigned TS = FS - 1;
  localparam int unsigned LW = $clog2(BS + 1);

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic [FS*DW-1:0] IN = '0;
  logic             i_valid = 1'b0;
  logic             next_ready;
  logic             i_flush = 1'b0;
  logic [DW-1:0]    OUT;
  logic             o_valid;
  logic             i_ready = 1'b0;
  logic             o_last;
  logic [LW-1:0]    o_level;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            n_pop = 0;
  logic [DW-1:0] mdl_tag = DW'(1);
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_out = '0;

  list_prefetch_cache #(.DW(DW), .FS(FS), .BS(BS)) u_dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN        (IN),
    .i_valid   (i_valid),
    .next_ready(next_ready),
    .i_flush   (i_flush),
    .OUT       (OUT),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_last    (o_last),
    .o_level   (o_level)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Present a packet until accepted; payload word k = base+k-1.
  task automatic send_pkt(input logic [DW-1:0] tag, input int base);
    bit ok;
    ok = 1'b0;
    IN[DW-1:0] = tag;
    for (int k = 1; k < FS; k++) IN[k*DW +: DW] = DW'(base + k - 1);
    i_valid = 1'b1;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge CLK);
      if (next_ready) begin
        ok = 1'b1;
        if (tag != mdl_tag) begin
          for (int k = 1; k < FS; k++) begin
            exp_q.push_back('{data: DW'(base + k - 1), last: (k == FS - 1)});
          end
          mdl_tag = tag;
        end
      end
      @(posedge CLK);
      #1;
    end
    i_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(posedge CLK);
      #1;
      if (exp_q.size() == 0 && !o_valid) done = 1'b1;
    end
    chk("drain_done", DW'(done), 1);
    chk("drain_level", DW'(o_level), 0);
    chk("drain_valid", DW'(o_valid), 0);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    exp_q.delete();
    mdl_tag = DW'(1);
  endtask

  function automatic logic [DW-1:0] next_tag();
    return (mdl_tag == '0) ? DW'(1) : DW'(0);
  endfunction

  // Output monitor: ordered delivery plus hold-under-backpressure.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_data", OUT, prev_out);
          chk("hold_valid", DW'(o_valid), 1);
        end
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_word", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("data", OUT, e.data);
            chk("last", DW'(o_last), DW'(e.last));
            n_pop++;
          end
        end
        prev_stall = o_valid && !i_ready && !i_flush;
        prev_out   = OUT;
      end
    end
  end

  initial begin
    int base;
    bit hit;

    // Reset state
    #2;
    chk("rst_out", OUT, 0);
    chk("rst_valid", DW'(o_valid), 0);
    chk("rst_last", DW'(o_last), 0);
    chk("rst_level", DW'(o_level), 0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // 1: single packet streamed
    i_ready = 1'b1;
    base = n_pop;
    send_pkt(0, 1);
    drain();
    chk("t1_words", DW'(n_pop - base), TS);

    // 2: fill, full, then third packet after a line frees
    do_reset();
    i_ready = 1'b0;
    base = n_pop;
    send_pkt(0, 1);
    send_pkt(1, 8);
    @(negedge CLK);
    chk("t2_level_full", DW'(o_level), BS);
    chk("t2_not_ready", DW'(next_ready), 0);
    fork
      send_pkt(0, 15);
      begin
        repeat (3) @(posedge CLK);
        #1;
        i_ready = 1'b1;
      end
    join
    drain();
    chk("t2_words", DW'(n_pop - base), 3 * TS);

    // 3: duplicate tag dropped
    do_reset();
    i_ready = 1'b0;
    base = n_pop;
    send_pkt(0, 10);
    send_pkt(0, 20);
    @(negedge CLK);
    chk("t3_level", DW'(o_level), 1);
    chk("t3_ready", DW'(next_ready), 1);
    @(posedge CLK);
    #1;
    i_ready = 1'b1;
    drain();
    chk("t3_words", DW'(n_pop - base), TS);

    // 4: random backpressure
    base = n_pop;
    fork
      for (int p = 0; p < 4; p++) send_pkt(next_tag(), 100 + 10 * p);
      begin
        repeat (80) begin
          @(posedge CLK);
          #1;
          i_ready = 1'($urandom_range(0, 1));
        end
        i_ready = 1'b1;
      end
    join
    drain();
    chk("t4_words", DW'(n_pop - base), 4 * TS);

    // 5: flush mid-line with a second line stored
    i_ready = 1'b0;
    send_pkt(next_tag(), 200);
    send_pkt(next_tag(), 300);
    base = n_pop;
    i_ready = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge CLK);
      #1;
      if (n_pop - base >= 3) hit = 1'b1;
    end
    chk("t5_three_words", DW'(hit), 1);
    i_ready = 1'b0;
    i_flush = 1'b1;
    @(posedge CLK);
    #1;
    i_flush = 1'b0;
    exp_q.delete();
    chk("t5_valid", DW'(o_valid), 0);
    chk("t5_last", DW'(o_last), 0);
    chk("t5_level", DW'(o_level), 0);
    i_ready = 1'b1;
    base = n_pop;
    send_pkt(next_tag(), 400);
    drain();
    chk("t5_words", DW'(n_pop - base), TS);

    // 6: asynchronous reset mid-line
    base = n_pop;
    send_pkt(next_tag(), 500);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge CLK);
      #1;
      if (n_pop - base >= 2) hit = 1'b1;
    end
    chk("t6_two_words", DW'(hit), 1);
    #2;
    RESET = 1'b1;
    #1;
    chk("t6_out", OUT, 0);
    chk("t6_valid", DW'(o_valid), 0);
    chk("t6_last", DW'(o_last), 0);
    chk("t6_level", DW'(o_level), 0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    exp_q.delete();
    mdl_tag = DW'(1);
    base = n_pop;
    send_pkt(0, 600);
    drain();
    chk("t6_words", DW'(n_pop - base), TS);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
